// File: rtl/uart_cordic_seq_pkg.sv
// Shared definitions for the UART <-> CORDIC ln transaction sequencer.
// Holds the FSM state encodings and the default frame and timeout sizes.
package uart_cordic_seq_pkg;

   localparam int N_IN_DEF   = 4;
   localparam int N_OUT_DEF  = 4;
   localparam int TO_CYC_DEF = 50000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RECV   = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_SEND   = 3'd4,
      S_TXWAIT = 3'd5
   } state_t;

endpackage

// File: rtl/uart_cordic_seq_shreg.sv
// Byte-lane register: clear, parallel load, byte-wide left shift or single-lane write.
// Parallel contents and one selected lane are both presented as outputs.
module byte_shreg #(
   parameter int N_BYTES = 4,
   parameter int LANE_W  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clr_i,
   input  logic                   ld_i,
   input  logic                   shift_i,
   input  logic                   wr_i,
   input  logic [LANE_W-1:0]      lane_i,
   input  logic [7:0]             byte_i,
   input  logic [8*N_BYTES-1:0]   pdat_i,
   output logic [8*N_BYTES-1:0]   pdat_o,
   output logic [7:0]             byte_o
);

   logic [8*N_BYTES-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = '0;
      end else if (ld_i) begin
         data_d = pdat_i;
      end else if (shift_i) begin
         data_d = (data_q << 8) | (8*N_BYTES)'(byte_i);
      end else if (wr_i) begin
         data_d[8*lane_i +: 8] = byte_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) data_q <= '0;
      else         data_q <= data_d;
   end

   assign pdat_o = data_q;
   assign byte_o = data_q[8*lane_i +: 8];

endmodule

// File: rtl/uart_cordic_seq.sv
// Sequences one CORDIC ln transaction: gather N_IN RX bytes, run the core,
// then stream N_OUT result bytes to the UART transmitter MSB first.
module uart_cordic_seq
   import uart_cordic_seq_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int TO_CYC = TO_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_ready,
   input  logic [7:0]           rx_data,
   output logic                 cordic_start,
   output logic [8*N_IN-1:0]    cordic_operand,
   input  logic                 cordic_done,
   input  logic [8*N_OUT-1:0]   cordic_result,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic                 err
);

   localparam int CW = $clog2(N_IN + 1);
   localparam int TW = $clog2(N_OUT + 1);
   localparam int OW = $clog2(TO_CYC);

   state_t          state_q, state_d;
   logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [OW-1:0]   to_cnt_q, to_cnt_d;
   logic            cordic_start_q, cordic_start_d;
   logic            tx_start_q, tx_start_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;

   logic            timeout, last_byte;
   logic            rx_clr, rx_ld, rx_wr, tx_ld, tx_shift;
   logic [CW-1:0]   rx_lane;
   logic [8*N_IN-1:0]  rx_first;
   logic [7:0]         rx_byte_unused;
   logic [8*N_OUT-1:0] tx_par_unused;

   // A byte arriving on the terminal count wins over the abort.
   assign timeout   = (state_q == S_RECV) && (to_cnt_q == OW'(TO_CYC - 1)) && !rx_ready;
   assign last_byte = (byte_cnt_q == CW'(N_IN - 1));
   assign rx_lane   = CW'(N_IN - 1) - byte_cnt_q;
   assign rx_first  = (8*N_IN)'(rx_data) << (8*(N_IN - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         byte_cnt_q     <= '0;
         tx_cnt_q       <= '0;
         to_cnt_q       <= '0;
         cordic_start_q <= 1'b0;
         tx_start_q     <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         tx_cnt_q       <= tx_cnt_d;
         to_cnt_q       <= to_cnt_d;
         cordic_start_q <= cordic_start_d;
         tx_start_q     <= tx_start_d;
         busy_q         <= busy_d;
         err_q          <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (rx_ready) state_d = (N_IN == 1) ? S_START : S_RECV;
         S_RECV: begin
            if (rx_ready && last_byte) state_d = S_START;
            else if (timeout)          state_d = S_IDLE;
         end
         S_START:  state_d = S_WAIT;
         S_WAIT:   if (cordic_done) state_d = S_SEND;
         S_SEND:   state_d = S_TXWAIT;
         S_TXWAIT: if (tx_done) state_d = (tx_cnt_q == TW'(N_OUT - 1)) ? S_IDLE : S_SEND;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath strobes, counters and the registered pulse outputs.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      tx_cnt_d   = tx_cnt_q;
      to_cnt_d   = '0;
      rx_clr     = 1'b0;
      rx_ld      = 1'b0;
      rx_wr      = 1'b0;
      tx_ld      = 1'b0;
      tx_shift   = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_ready) begin
               rx_ld      = 1'b1;
               byte_cnt_d = CW'(1);
            end
         end
         S_RECV: begin
            if (rx_ready) begin
               rx_wr      = 1'b1;
               byte_cnt_d = byte_cnt_q + 1'b1;
            end else if (timeout) begin
               rx_clr     = 1'b1;
               err_d      = 1'b1;
               byte_cnt_d = '0;
            end else begin
               to_cnt_d   = to_cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            err_d = rx_ready;
            if (cordic_done) begin
               tx_ld    = 1'b1;
               tx_cnt_d = '0;
            end
         end
         S_TXWAIT: begin
            err_d = rx_ready;
            if (tx_done) begin
               tx_shift = 1'b1;
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: err_d = rx_ready;
      endcase
      cordic_start_d = (state_d == S_START);
      tx_start_d     = (state_d == S_SEND);
      busy_d         = (state_d != S_IDLE);
   end

   byte_shreg #(.N_BYTES(N_IN), .LANE_W(CW)) u_rx_shreg (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (rx_clr),
      .ld_i    (rx_ld),
      .shift_i (1'b0),
      .wr_i    (rx_wr),
      .lane_i  (rx_lane),
      .byte_i  (rx_data),
      .pdat_i  (rx_first),
      .pdat_o  (cordic_operand),
      .byte_o  (rx_byte_unused)
   );

   // Result shifts up one byte per tx_done so the MSB lane always holds the byte on the wire.
   byte_shreg #(.N_BYTES(N_OUT), .LANE_W(TW)) u_tx_shreg (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (1'b0),
      .ld_i    (tx_ld),
      .shift_i (tx_shift),
      .wr_i    (1'b0),
      .lane_i  (TW'(N_OUT - 1)),
      .byte_i  (8'h00),
      .pdat_i  (cordic_result),
      .pdat_o  (tx_par_unused),
      .byte_o  (tx_data)
   );

   assign cordic_start = cordic_start_q;
   assign tx_start     = tx_start_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule
